// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg: MMIO address map and STATUS layout for dmem_mmio.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam logic [11:0] MMIO_BASE   = 12'hF00;
    localparam logic [11:0] ADDR_CYCLE  = 12'hF00;
    localparam logic [11:0] ADDR_TXDATA = 12'hF04;
    localparam logic [11:0] ADDR_STATUS = 12'hF08;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_HALTED    = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/dmem_mmio_tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo: byte FIFO with valid/ready drain and drop-on-full report.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_fifo #(
    parameter  int FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             ready,
    output logic [7:0]       head,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             dropped
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;
    logic             accept;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign valid   = !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign pop     = valid && ready;
    // A pop at the same edge frees the slot, so a push into a full FIFO still lands.
    assign accept  = push && (!full || pop);
    assign dropped = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------
// dmem_mmio: data RAM plus cycle counter / console FIFO MMIO window.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RAM_WORDS  = 960,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    input  logic                  ebreak_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-3:0] ram_idx;
    logic                  sel_ram;
    logic                  wr_cycle;
    logic                  wr_txdata;
    logic                  clr_overflow;

    logic [31:0]           ram [RAM_WORDS];
    logic [31:0]           cycle;
    logic                  halted;
    logic                  overflow;
    logic [31:0]           status_word;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_dropped;
    logic [CNT_W-1:0]      fifo_count;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^data_addr_i[1:0];

    assign ram_idx      = data_addr_i[ADDR_WIDTH-1:2];
    assign word_addr    = {ram_idx, 2'b00};
    assign sel_ram      = (word_addr < ADDR_WIDTH'(MMIO_BASE)) && (int'(ram_idx) < RAM_WORDS);
    assign wr_cycle     = mem_wr_i && (word_addr == ADDR_WIDTH'(ADDR_CYCLE));
    assign wr_txdata    = mem_wr_i && (word_addr == ADDR_WIDTH'(ADDR_TXDATA));
    assign clr_overflow = mem_wr_i && (word_addr == ADDR_WIDTH'(ADDR_STATUS)) && data_i[STAT_OVERFLOW];

    always_ff @(posedge clk_i) begin
        if (mem_wr_i && sel_ram) ram[ram_idx] <= data_i;
    end

    // A CYCLE write wins over the increment even when halted; halting uses the pre-edge flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycle    <= '0;
            halted   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_cycle)     cycle <= data_i;
            else if (!halted) cycle <= cycle + 32'd1;
            if (ebreak_i)     halted <= 1'b1;
            if (fifo_dropped) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_comb begin
        status_word                                = '0;
        status_word[STAT_EMPTY]                    = fifo_empty;
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_OVERFLOW]                 = overflow;
        status_word[STAT_HALTED]                   = halted;
        status_word[STAT_COUNT_LSB +: CNT_W]       = fifo_count;
    end

    always_comb begin
        data_o = '0;
        if (sel_ram)                                       data_o = ram[ram_idx];
        else if (word_addr == ADDR_WIDTH'(ADDR_CYCLE))     data_o = cycle;
        else if (word_addr == ADDR_WIDTH'(ADDR_STATUS))    data_o = status_word;
    end

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (wr_txdata),
        .push_data (data_i[7:0]),
        .ready     (tx_ready_i),
        .head      (tx_data_o),
        .valid     (tx_valid_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .dropped   (fifo_dropped)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
// ---------------------------------------------------------------------------
// tb_dmem_mmio: scoreboard bench for dmem_mmio against a behavioural model.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_mmio;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        mem_wr_i;
    logic [11:0] data_addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ebreak_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    always #5 clk = ~clk;

    dmem_mmio #(
        .ADDR_WIDTH (12),
        .RAM_WORDS  (960),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .mem_wr_i    (mem_wr_i),
        .data_addr_i (data_addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .ebreak_i    (ebreak_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i)
    );

    // Behavioural model state
    int unsigned  m_cycle;
    bit           m_halted;
    bit           m_ovf;
    byte unsigned m_fifo[$];
    logic [31:0]  m_ram[int];

    // Scoreboard queues
    logic [31:0]  rd_q[$];
    logic [8:0]   tx_q[$];
    byte unsigned emit_q[$];
    bit           rd_chk = 1'b0;
    logic [8:0]   mon_snap;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_cycle  = 0;
        m_halted = 1'b0;
        m_ovf    = 1'b0;
        m_fifo.delete();
        m_ram.delete();
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_fifo.size() == 0);
        s[1]    = (m_fifo.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_halted;
        s[11:8] = 4'(m_fifo.size());
        return s;
    endfunction

    task automatic cycle(input bit wr, input logic [11:0] addr, input logic [31:0] d,
                         input bit eb, input bit rdy, input bit rst);
        logic [11:0] a;
        logic [8:0]  snap;
        @(posedge clk);
        #1;
        rstn_i      = !rst;
        mem_wr_i    = wr;
        data_addr_i = addr;
        data_i      = d;
        ebreak_i    = eb;
        tx_ready_i  = rdy;
        if (rst) model_reset();
        a = addr & 12'hFFC;

        snap[8]   = (m_fifo.size() != 0);
        snap[7:0] = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
        tx_q.push_back(snap);

        rd_chk = 1'b0;
        if (!wr) begin
            if (a < 12'hF00) begin
                if (m_ram.exists(int'(a[11:2]))) begin
                    rd_q.push_back(m_ram[int'(a[11:2])]);
                    rd_chk = 1'b1;
                end
            end else begin
                rd_chk = 1'b1;
                if (a == 12'hF00)      rd_q.push_back(m_cycle);
                else if (a == 12'hF08) rd_q.push_back(model_status());
                else                   rd_q.push_back(32'h0);
            end
        end

        // State after the coming edge
        if (!rst) begin
            if (m_fifo.size() != 0 && rdy) emit_q.push_back(m_fifo.pop_front());
            if (wr && a == 12'hF04) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]);
                else                       m_ovf = 1'b1;
            end
            if (wr && a == 12'hF08 && d[2]) m_ovf = 1'b0;
            if (wr && a == 12'hF00)  m_cycle = d;
            else if (!m_halted)      m_cycle = m_cycle + 1;
            if (eb) m_halted = 1'b1;
            if (wr && a < 12'hF00) m_ram[int'(a[11:2])] = d;
        end
    endtask

    task automatic rd(input logic [11:0] addr, input bit rdy);
        cycle(1'b0, addr, 32'h0, 1'b0, rdy, 1'b0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] d, input bit rdy);
        cycle(1'b1, addr, d, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents this cycle against queued expectations
    always @(negedge clk) begin
        if (tx_q.size() != 0) begin
            mon_snap = tx_q.pop_front();
            check("tx_valid", {31'h0, tx_valid_o}, {31'h0, mon_snap[8]});
            check("tx_data", {24'h0, tx_data_o}, {24'h0, mon_snap[7:0]});
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) check("read_underflow", 32'h1, 32'h0);
            else                  check("read_data", data_o, rd_q.pop_front());
        end
        if (rstn_i && tx_valid_o && tx_ready_i) begin
            if (emit_q.size() == 0) check("tx_stream_extra", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
            else                    check("tx_stream", {24'h0, tx_data_o}, {24'h0, emit_q.pop_front()});
        end
    end

    initial begin
        int bias;
        logic [11:0] addr;
        logic [31:0] d;
        int sel;

        rstn_i = 1'b0; mem_wr_i = 1'b0; data_addr_i = '0; data_i = '0;
        ebreak_i = 1'b0; tx_ready_i = 1'b0;
        model_reset();

        cycle(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 12'hF08, 32'h0, 1'b0, 1'b0, 1'b1);
        rd(12'hF08, 1'b0);
        rd(12'hF00, 1'b0); rd(12'hF00, 1'b0); rd(12'hF00, 1'b0);

        wr(12'h010, 32'hDEADBEEF, 1'b0);
        wr(12'hEFC, 32'h12345678, 1'b0);
        rd(12'h010, 1'b0); rd(12'hEFF, 1'b0);
        wr(12'hF0C, 32'h55, 1'b0);
        rd(12'hF0C, 1'b0); rd(12'h012, 1'b0); rd(12'hF04, 1'b0);

        wr(12'hF00, 32'hFFFF_FFFE, 1'b0);
        rd(12'hF00, 1'b0); rd(12'hF00, 1'b0); rd(12'hF00, 1'b0);
        cycle(1'b0, 12'hF00, 32'h0, 1'b1, 1'b0, 1'b0);
        rd(12'hF00, 1'b0); rd(12'hF00, 1'b0); rd(12'hF08, 1'b0);
        wr(12'hF00, 32'd5, 1'b0);
        rd(12'hF00, 1'b0); rd(12'hF00, 1'b0); rd(12'hF00, 1'b0);

        for (int i = 0; i < 8; i++) wr(12'hF04, 32'h41 + i, 1'b0);
        rd(12'hF08, 1'b0);
        wr(12'hF04, 32'h49, 1'b0);
        rd(12'hF08, 1'b0);
        wr(12'hF08, 32'h4, 1'b0);
        rd(12'hF08, 1'b0);
        for (int i = 0; i < 9; i++) rd(12'hF08, 1'b1);

        for (int i = 0; i < 8; i++) wr(12'hF04, 32'h61 + i, 1'b0);
        wr(12'hF04, 32'h5A, 1'b1);
        rd(12'hF08, 1'b0);
        for (int i = 0; i < 9; i++) rd(12'hF08, 1'b1);

        for (int i = 0; i < 6; i++) wr(12'hF04, 32'h30 + i, 1'b0);
        rd(12'hF08, 1'b1); rd(12'hF08, 1'b1);
        cycle(1'b0, 12'hF08, 32'h0, 1'b0, 1'b1, 1'b1);
        rd(12'hF08, 1'b1); rd(12'hF00, 1'b1); rd(12'hF00, 1'b1);

        bias = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) bias = int'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: addr = 12'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                3:       addr = 12'hEFC | 12'($urandom_range(0, 3));
                4, 5:    addr = 12'hF00 | 12'($urandom_range(0, 3));
                6, 7:    addr = 12'hF04 | 12'($urandom_range(0, 3));
                8:       addr = 12'hF08 | 12'($urandom_range(0, 3));
                default: addr = 12'($urandom());
            endcase
            d = $urandom();
            if (sel == 4 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 1)), addr, d,
                  $urandom_range(0, 299) == 0,
                  int'($urandom_range(0, 3)) < bias,
                  $urandom_range(0, 399) == 0);
        end

        @(posedge clk);
        #1;
        rd_chk = 1'b0;
        mem_wr_i = 1'b0;
        @(negedge clk);
        #1;
        check("rd_q_drained", rd_q.size(), 32'd0);
        check("emit_q_drained", emit_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
